// File: rtl/iterative_control_pkg.sv
// Shared FSM state encoding and operation-mode constants for the iterative divide/sqrt controller.
package iterative_control;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic MODE_DIVIDE = 1'b0;
  localparam logic MODE_SQRT   = 1'b1;

endpackage

// File: rtl/iterative_unit_controller.sv
// Request/result sequencer around an iterative divide/sqrt unit.
// Optional WAIT watchdog enabled by defining ITERATIVE_TIMEOUT_EN.
module iterative_unit_controller
  import iterative_control::*;
#(
  parameter int unsigned QUOTIENT_WIDTH  = 26,
  parameter int unsigned REMAINDER_WIDTH = 27,
  parameter int unsigned TAG_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_mode,
  input  logic [TAG_WIDTH-1:0]       req_tag,
  output logic                       divider_start,
  output logic                       divider_mode,
  input  logic                       busy,
  input  logic                       done,
  input  logic [QUOTIENT_WIDTH-1:0]  quotient_root,
  input  logic [REMAINDER_WIDTH-1:0] remainder,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [QUOTIENT_WIDTH-1:0]  result_quotient_root,
  output logic                       result_inexact,
  output logic                       result_mode,
  output logic [TAG_WIDTH-1:0]       result_tag,
  output logic                       stall,
  output logic                       timeout_error
);

  state_e                      state_q, state_d;
  logic                        mode_q, mode_d;
  logic [TAG_WIDTH-1:0]        tag_q, tag_d;
  logic                        start_q, start_d;
  logic                        dmode_q, dmode_d;
  logic                        rvalid_q, rvalid_d;
  logic                        terr_q, terr_d;
  logic [QUOTIENT_WIDTH-1:0]   rquot_q, rquot_d;
  logic                        rinex_q, rinex_d;
  logic                        rmode_q, rmode_d;
  logic [TAG_WIDTH-1:0]        rtag_q, rtag_d;
  logic                        wd_expired;

`ifdef ITERATIVE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wd_cnt_q;

  // Counts WAIT cycles; held at zero elsewhere so it restarts on each WAIT entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else if (state_q != WAIT) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + CntW'(1);
    end
  end

  assign wd_expired = (state_q == WAIT) && (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign wd_expired     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    rquot_d = rquot_q;
    rinex_d = rinex_q;
    rmode_d = rmode_q;
    rtag_d  = rtag_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !busy) begin
          mode_d  = req_mode;
          tag_d   = req_tag;
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (done) begin
          rquot_d = quotient_root;
          rinex_d = |remainder;
          rmode_d = mode_q;
          rtag_d  = tag_q;
          state_d = HOLD;
        end else if (wd_expired) begin
          rquot_d = '0;
          rinex_d = 1'b1;
          rmode_d = mode_q;
          rtag_d  = tag_q;
          terr_d  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Output registers are loaded from the next state so they align with it.
    start_d  = (state_d == START);
    dmode_d  = ((state_d == START) || (state_d == WAIT)) ? mode_d : MODE_DIVIDE;
    rvalid_d = (state_d == HOLD);
    if (state_d != HOLD) begin
      terr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_DIVIDE;
      tag_q    <= '0;
      start_q  <= 1'b0;
      dmode_q  <= 1'b0;
      rvalid_q <= 1'b0;
      terr_q   <= 1'b0;
      rquot_q  <= '0;
      rinex_q  <= 1'b0;
      rmode_q  <= 1'b0;
      rtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      tag_q    <= tag_d;
      start_q  <= start_d;
      dmode_q  <= dmode_d;
      rvalid_q <= rvalid_d;
      terr_q   <= terr_d;
      rquot_q  <= rquot_d;
      rinex_q  <= rinex_d;
      rmode_q  <= rmode_d;
      rtag_q   <= rtag_d;
    end
  end

  // Handshake signals react to the current request in the same cycle.
  assign req_ready = (state_q == IDLE) && !busy;
  assign stall     = (state_q != IDLE) || req_valid;

  assign divider_start        = start_q;
  assign divider_mode         = dmode_q;
  assign result_valid         = rvalid_q;
  assign result_quotient_root = rquot_q;
  assign result_inexact       = rinex_q;
  assign result_mode          = rmode_q;
  assign result_tag           = rtag_q;
  assign timeout_error        = terr_q;

endmodule

// File: tb/tb_iterative_unit_controller.sv
// Directed, table-driven bench for iterative_unit_controller (watchdog test when ITERATIVE_TIMEOUT_EN is defined).
module tb_iterative_unit_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_mode;
  logic [3:0]  req_tag;
  logic        divider_start, divider_mode, busy, done;
  logic [25:0] quotient_root;
  logic [26:0] remainder;
  logic        result_valid, result_ready;
  logic [25:0] result_quotient_root;
  logic        result_inexact, result_mode;
  logic [3:0]  result_tag;
  logic        stall, timeout_error;

  int checks = 0;
  int failures = 0;

  iterative_unit_controller #(
    .QUOTIENT_WIDTH(26), .REMAINDER_WIDTH(27), .TAG_WIDTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_tag(req_tag), .divider_start(divider_start),
    .divider_mode(divider_mode), .busy(busy), .done(done),
    .quotient_root(quotient_root), .remainder(remainder),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_quotient_root(result_quotient_root), .result_inexact(result_inexact),
    .result_mode(result_mode), .result_tag(result_tag), .stall(stall),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [3:0]  tag;
    int          lat;
    logic [25:0] q;
    logic [26:0] r;
    logic        exp_inexact;
    int          hold;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept, run through START/WAIT, capture, hold under backpressure, release.
  task automatic run_op(input vec_t v);
    req_valid = 1'b1; req_mode = v.mode; req_tag = v.tag;
    #1;
    check("accept_ready", 64'(req_ready), 64'(1));
    check("accept_stall", 64'(stall), 64'(1));
    step();
    req_valid = 1'b0; req_mode = 1'b0; req_tag = 4'h0;
    check("start_pulse", 64'(divider_start), 64'(1));
    check("start_mode", 64'(divider_mode), 64'(v.mode));
    check("start_ready", 64'(req_ready), 64'(0));
    step();
    for (int i = 1; i < v.lat; i++) begin
      check("wait_start", 64'(divider_start), 64'(0));
      check("wait_mode", 64'(divider_mode), 64'(v.mode));
      check("wait_valid", 64'(result_valid), 64'(0));
      step();
    end
    check("wait_mode_last", 64'(divider_mode), 64'(v.mode));
    done = 1'b1; quotient_root = v.q; remainder = v.r;
    step();
    done = 1'b0; quotient_root = '0; remainder = '0;
    check("hold_valid", 64'(result_valid), 64'(1));
    check("hold_quot", 64'(result_quotient_root), 64'(v.q));
    check("hold_inexact", 64'(result_inexact), 64'(v.exp_inexact));
    check("hold_mode", 64'(result_mode), 64'(v.mode));
    check("hold_tag", 64'(result_tag), 64'(v.tag));
    check("hold_dmode", 64'(divider_start), 64'(0));
    check("hold_terr", 64'(timeout_error), 64'(0));
    for (int h = 0; h < v.hold; h++) begin
      // Spurious done in HOLD with different data must be ignored.
      done = (h == 0); quotient_root = ~v.q; remainder = 27'h1;
      step();
      done = 1'b0; quotient_root = '0; remainder = '0;
      check("bp_valid", 64'(result_valid), 64'(1));
      check("bp_quot", 64'(result_quotient_root), 64'(v.q));
      check("bp_inexact", 64'(result_inexact), 64'(v.exp_inexact));
      check("bp_tag", 64'(result_tag), 64'(v.tag));
      check("bp_ready", 64'(req_ready), 64'(0));
      check("bp_stall", 64'(stall), 64'(1));
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("rel_valid", 64'(result_valid), 64'(0));
    check("rel_ready", 64'(req_ready), 64'(1));
    check("rel_stall", 64'(stall), 64'(0));
    check("rel_quot_kept", 64'(result_quotient_root), 64'(v.q));
    check("rel_tag_kept", 64'(result_tag), 64'(v.tag));
  endtask

  initial begin
    vecs[0] = '{mode: 1'b0, tag: 4'h5, lat: 26, q: 26'h2000000, r: 27'h0,       exp_inexact: 1'b0, hold: 10};
    vecs[1] = '{mode: 1'b1, tag: 4'hA, lat: 13, q: 26'h0001234, r: 27'h1,       exp_inexact: 1'b1, hold: 2};
    vecs[2] = '{mode: 1'b0, tag: 4'hF, lat: 1,  q: 26'h3FFFFFF, r: 27'h4000000, exp_inexact: 1'b1, hold: 0};
    vecs[3] = '{mode: 1'b1, tag: 4'h0, lat: 3,  q: 26'h0000000, r: 27'h0,       exp_inexact: 1'b0, hold: 1};

    reset = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_tag = 4'h0;
    busy = 1'b0; done = 1'b0; quotient_root = '0; remainder = '0; result_ready = 1'b0;
    repeat (3) step();
    check("rst_start", 64'(divider_start), 64'(0));
    check("rst_dmode", 64'(divider_mode), 64'(0));
    check("rst_valid", 64'(result_valid), 64'(0));
    check("rst_terr", 64'(timeout_error), 64'(0));
    check("rst_quot", 64'(result_quotient_root), 64'(0));
    check("rst_tag", 64'(result_tag), 64'(0));
    reset = 1'b0;

    for (int k = 0; k < 4; k++) run_op(vecs[k]);

    // Spurious done in IDLE.
    done = 1'b1; quotient_root = 26'h155; remainder = 27'h3;
    step();
    done = 1'b0; quotient_root = '0; remainder = '0;
    check("idle_done_valid", 64'(result_valid), 64'(0));
    check("idle_done_ready", 64'(req_ready), 64'(1));
    check("idle_done_quot", 64'(result_quotient_root), 64'(vecs[3].q));
    check("idle_done_inexact", 64'(result_inexact), 64'(0));

    // Request while busy waits in IDLE.
    busy = 1'b1; req_valid = 1'b1; req_mode = 1'b1; req_tag = 4'h3;
    #1;
    check("busy_ready", 64'(req_ready), 64'(0));
    check("busy_stall", 64'(stall), 64'(1));
    step();
    check("busy_nostart", 64'(divider_start), 64'(0));
    busy = 1'b0;
    #1;
    check("busy_clear_ready", 64'(req_ready), 64'(1));
    step();
    req_valid = 1'b0;
    check("busy_then_start", 64'(divider_start), 64'(1));
    check("busy_then_mode", 64'(divider_mode), 64'(1));

    // Asynchronous reset in WAIT.
    step(); step();
    check("prerst_wait_mode", 64'(divider_mode), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_dmode", 64'(divider_mode), 64'(0));
    check("arst_valid", 64'(result_valid), 64'(0));
    check("arst_quot", 64'(result_quotient_root), 64'(0));
    check("arst_tag", 64'(result_tag), 64'(0));
    check("arst_terr", 64'(timeout_error), 64'(0));
    step();
    reset = 1'b0;
    check("post_rst_ready", 64'(req_ready), 64'(1));
    run_op(vecs[1]);

`ifdef ITERATIVE_TIMEOUT_EN
    req_valid = 1'b1; req_mode = 1'b1; req_tag = 4'h9;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 1; i < 8; i++) begin
      check("to_wait_valid", 64'(result_valid), 64'(0));
      step();
    end
    check("to_wait8_valid", 64'(result_valid), 64'(0));
    step();
    check("to_valid", 64'(result_valid), 64'(1));
    check("to_terr", 64'(timeout_error), 64'(1));
    check("to_quot", 64'(result_quotient_root), 64'(0));
    check("to_inexact", 64'(result_inexact), 64'(1));
    check("to_tag", 64'(result_tag), 64'(4'h9));
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("to_terr_clear", 64'(timeout_error), 64'(0));
    check("to_idle", 64'(req_ready), 64'(1));
`else
    req_valid = 1'b1; req_mode = 1'b0; req_tag = 4'h9;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("nowd_valid", 64'(result_valid), 64'(0));
      check("nowd_terr", 64'(timeout_error), 64'(0));
    end
    done = 1'b1; quotient_root = 26'h7; remainder = 27'h0;
    step();
    done = 1'b0;
    check("nowd_done_valid", 64'(result_valid), 64'(1));
    check("nowd_done_quot", 64'(result_quotient_root), 64'(26'h7));
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iterative_unit_controller.md
ITERATIVE_UNIT_CONTROLLER -- requirements
Module: iterative_unit_controller

Interface
REQ-001 SHALL have parameter QUOTIENT_WIDTH, default 26, quotient/root width from the iterative divide/sqrt unit.
REQ-002 SHALL have parameter REMAINDER_WIDTH, default 27, remainder width from the iterative unit.
REQ-003 SHALL have parameter TAG_WIDTH, default 4, opaque request tag carried to the result.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit in WAIT (used only when the macro in REQ-027 is defined).
REQ-005 SHALL have a single clock, clk; reset is asynchronous and active-high, port name reset.
REQ-006 Ports, in this order:
- clk, input, 1: clock.
- reset, input, 1: asynchronous active-high reset.
- req_valid, input, 1: operation request.
- req_ready, output, 1: controller can accept a request.
- req_mode, input, 1: 0 = divide, 1 = square root.
- req_tag, input, TAG_WIDTH: request tag.
- divider_start, output, 1: start pulse to the iterative unit.
- divider_mode, output, 1: mode to the iterative unit.
- busy, input, 1: from the iterative unit.
- done, input, 1: from the iterative unit, one-cycle result strobe.
- quotient_root, input, QUOTIENT_WIDTH: iterative unit result.
- remainder, input, REMAINDER_WIDTH: iterative unit remainder.
- result_valid, output, 1: result held.
- result_ready, input, 1: downstream accepts.
- result_quotient_root, output, QUOTIENT_WIDTH: captured result.
- result_inexact, output, 1: captured remainder nonzero.
- result_mode, output, 1: mode of the captured result.
- result_tag, output, TAG_WIDTH: tag of the captured result.
- stall, output, 1: upstream pipeline must hold.
- timeout_error, output, 1: watchdog fired.

Function
REQ-007 SHALL implement FSM states IDLE, START, WAIT, HOLD.
REQ-008 IDLE: req_ready=1; on req_valid, latch req_mode and req_tag, then go to START next cycle.
REQ-009 START: divider_start=1 for exactly one cycle, then go to WAIT unconditionally.
REQ-010 divider_mode SHALL equal the latched mode from START through WAIT and hold stable; it is 0 in IDLE.
REQ-011 WAIT: on done=1, capture quotient_root, result_inexact = OR-reduction of remainder, mode and tag, then go to HOLD.
REQ-012 HOLD: result_valid=1 with all result_* outputs stable; on result_ready=1, go to IDLE next cycle.
REQ-013 req_ready SHALL be 1 only in IDLE; there is no request acceptance in HOLD, so back-to-back throughput is one op per (unit latency + 3) cycles.
REQ-014 stall SHALL be 1 in START, WAIT and HOLD, and 1 in IDLE when req_valid=1.
REQ-015 done asserted in IDLE, START or HOLD SHALL be ignored, with no capture and no state change.
REQ-016 busy is informational; the controller SHALL NOT start while busy=1 in IDLE. Such a request waits in IDLE with req_ready forced to 0.
REQ-017 result_* registers SHALL change only on capture; they hold their value after leaving HOLD.
REQ-018 Latency: start pulse 1 cycle after acceptance; result_valid 1 cycle after the done cycle.

Reset
REQ-019 On reset: state IDLE; divider_start, divider_mode, result_valid and timeout_error = 0; all result_* registers = 0; latched mode and tag = 0.
REQ-020 Reset in any state SHALL abort the operation immediately; the same reset clears the iterative unit, and no result is produced.
REQ-021 First request acceptance SHALL be possible on the first clock edge after reset deasserts.

Configuration
REQ-027 Macro ITERATIVE_TIMEOUT_EN defined: a cycle counter runs in WAIT and clears on entry. On reaching TIMEOUT_CYCLES without done, the controller goes to HOLD with result_quotient_root=0, result_inexact=1 and timeout_error=1. timeout_error clears when leaving HOLD.
REQ-028 Macro undefined: no counter is built, timeout_error is tied to 0, and WAIT exits only on done.

Structure
REQ-029 The state enum and mode constants (MODE_DIVIDE=0, MODE_SQRT=1) SHALL live in a shared package, iterative_control.
REQ-030 The design SHALL be a single module; the optional watchdog is inline, with no sub-module.

Verification
REQ-031 Divide: req_mode=0, tag=5, done after 26 cycles with quotient_root=26'h2000000 and remainder=0. Expect divider_start one cycle, result_valid with quotient 26'h2000000, inexact=0, tag=5.
REQ-032 Sqrt: req_mode=1, remainder=27'h1. Expect divider_mode=1 throughout WAIT and result_inexact=1, result_mode=1.
REQ-033 Backpressure: result_ready=0 for 10 cycles in HOLD. Expect result_valid held, outputs stable, req_ready=0, stall=1; release and expect IDLE the next cycle.
REQ-034 Spurious done: pulse done in IDLE and in HOLD. Expect no capture and no state change.
REQ-035 Reset asserted mid-WAIT. Expect IDLE and all outputs 0 asynchronously; a new request is accepted after reset release.
REQ-036 With ITERATIVE_TIMEOUT_EN and TIMEOUT_CYCLES=8, done never asserted. Expect HOLD after 8 WAIT cycles, timeout_error=1, quotient 0.
